// File: rtl/pipelined_adder_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_adder_tree                                         |
// | Description : Registered binary adder tree over N unsigned W-bit elements, |
// |               followed by a saturating accumulator/output stage.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipelined_adder_tree #(
    parameter int N = 64,
    parameter int W = 4,
    parameter int A = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*W-1:0]                arr,
    input  logic                          acc_mode,
    input  logic                          acc_clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W+$clog2(N)+A-1:0]      sum,
    output logic                          ovf
);

    localparam int c_lvls = $clog2(N);
    localparam int c_tw   = W + c_lvls;
    localparam int c_sw   = W + c_lvls + A;

    // Bit offset of tree level lvl inside the flat node bus; level k holds
    // N>>k nodes of W+k bits each, level 0 being the raw input vector.
    function automatic int lvl_off(input int lvl);
        int s;
        s = 0;
        for (int k = 0; k < lvl; k++) begin
            s += (N >> k) * (W + k);
        end
        return s;
    endfunction

    localparam int c_bus_w    = lvl_off(c_lvls + 1);
    localparam int c_root_off = lvl_off(c_lvls);

    logic [c_bus_w-1:0] w_bus;
    logic [c_lvls:0]    w_vld;
    logic [c_lvls:0]    w_mode;
    logic [c_lvls:0]    w_clr;
    logic               w_advance;
    logic [c_sw-1:0]    w_total;
    logic [c_sw:0]      w_acc_sum;

    logic               r_out_valid;
    logic [c_sw-1:0]    r_sum;
    logic [c_sw-1:0]    r_acc;
    logic               r_ovf;

    // A single advance enable moves every stage together, so a stalled
    // output freezes the whole pipe without losing or duplicating entries.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    assign w_vld[0]         = in_valid && w_advance;
    assign w_mode[0]        = acc_mode;
    assign w_clr[0]         = acc_clr;
    assign w_bus[0 +: N*W]  = arr;

    for (genvar j = 1; j <= c_lvls; j++) begin : g_level
        localparam int c_iw   = W + j - 1;
        localparam int c_ow   = W + j;
        localparam int c_cnt  = N >> j;
        localparam int c_ioff = lvl_off(j - 1);
        localparam int c_ooff = lvl_off(j);

        logic [c_cnt*c_ow-1:0] w_sums;
        logic [c_cnt*c_ow-1:0] r_data;
        logic                  r_vld;
        logic                  r_mode;
        logic                  r_clr;

        for (genvar i = 0; i < c_cnt; i++) begin : g_add
            assign w_sums[i*c_ow +: c_ow] =
                {1'b0, w_bus[c_ioff + (2*i)*c_iw   +: c_iw]} +
                {1'b0, w_bus[c_ioff + (2*i+1)*c_iw +: c_iw]};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data <= '0;
                r_vld  <= 1'b0;
                r_mode <= 1'b0;
                r_clr  <= 1'b0;
            end else if (w_advance) begin
                r_data <= w_sums;
                r_vld  <= w_vld[j-1];
                r_mode <= w_mode[j-1];
                r_clr  <= w_clr[j-1];
            end
        end

        assign w_bus[c_ooff +: c_cnt*c_ow] = r_data;
        assign w_vld[j]                    = r_vld;
        assign w_mode[j]                   = r_mode;
        assign w_clr[j]                    = r_clr;
    end

    assign w_total   = c_sw'(w_bus[c_root_off +: c_tw]);
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_total};

    // Accumulator updates only on a valid entry moving through this stage;
    // bubbles and mode-0 entries leave acc and ovf untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_vld[c_lvls];
            if (w_vld[c_lvls]) begin
                if (!w_mode[c_lvls]) begin
                    r_sum <= w_total;
                end else if (w_clr[c_lvls]) begin
                    r_acc <= w_total;
                    r_sum <= w_total;
                    r_ovf <= 1'b0;
                end else if (w_acc_sum[c_sw]) begin
                    r_acc <= '1;
                    r_sum <= '1;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum[c_sw-1:0];
                    r_sum <= w_acc_sum[c_sw-1:0];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipelined_adder_tree                                      |
// | Description : Directed scoreboard bench for pipelined_adder_tree.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipelined_adder_tree;

    localparam int N   = 64;
    localparam int W   = 4;
    localparam int A   = 8;
    localparam int SW  = 18;
    localparam int LAT = 7;
    localparam int MAXV = 262143;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   arr;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    sum;
    logic             ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [SW-1:0] sum;
        logic          ovf;
        int            issue;
        bit            chk_lat;
    } exp_t;

    exp_t sb[$];

    pipelined_adder_tree #(.N(N), .W(W), .A(A)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .arr       (arr),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = v;
        return r;
    endfunction

    function automatic logic [N*W-1:0] ramp(input int m);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(k % m);
        return r;
    endfunction

    function automatic logic [N*W-1:0] single(input int pos, input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[pos*W +: W] = v;
        return r;
    endfunction

    // Present one vector, wait (bounded) for acceptance, record its expectation.
    task automatic send(input logic [N*W-1:0] a, input logic m, input logic c,
                        input int es, input bit eo, input bit lat);
        int   waited;
        exp_t e;
        waited   = 0;
        arr      = a;
        acc_mode = m;
        acc_clr  = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end else begin
            e.sum     = SW'(es);
            e.ovf     = eo;
            e.issue   = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 32'(sb.size()), 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 0);
                if (sb.size() != 0) begin
                    check("stall_sum_hold", 32'(sum), 32'(sb[0].sum));
                    check("stall_ovf_hold", 32'(ovf), 32'(sb[0].ovf));
                end
            end
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%0d required=no_output", sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    if (e.chk_lat) check("latency", 32'(cyc - e.issue), LAT);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        arr       = '0;
        acc_mode  = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // all-F, mode 0, latency check
        send(fill(4'hF), 1'b0, 1'b0, 960, 1'b0, 1'b1);
        drain();

        // 10 back-to-back ramp vectors
        for (int i = 0; i < 10; i++) send(ramp(16), 1'b0, 1'b0, 480, 1'b0, 1'b1);
        drain();

        // assorted patterns
        send(single(63, 4'hF), 1'b0, 1'b0, 15, 1'b0, 1'b0);
        send(single(0, 4'h1),  1'b0, 1'b0, 1,  1'b0, 1'b0);
        send(fill(4'h0),       1'b0, 1'b0, 0,  1'b0, 1'b0);
        send(ramp(4),          1'b0, 1'b0, 96, 1'b0, 1'b0);
        drain();

        // stall mid-stream
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(single((i * 7) % 64, W'(i + 1)), 1'b0, 1'b0, i + 1, 1'b0, 1'b0);
                idle(1);
            end
            begin
                repeat (9) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // accumulate
        send(fill(4'hF), 1'b1, 1'b1, 960,  1'b0, 1'b0);
        send(fill(4'hF), 1'b1, 1'b0, 1920, 1'b0, 1'b0);
        send(fill(4'hF), 1'b1, 1'b0, 2880, 1'b0, 1'b0);
        send(fill(4'hF), 1'b1, 1'b0, 3840, 1'b0, 1'b0);
        send(fill(4'h1), 1'b0, 1'b0, 64,   1'b0, 1'b0);
        send(fill(4'h1), 1'b1, 1'b0, 3904, 1'b0, 1'b0);
        drain();

        // saturation: 274 * 960 = 263040 exceeds 262143
        for (int k = 1; k <= 275; k++) begin
            v = k * 960;
            send(fill(4'hF), 1'b1, (k == 1), (v > MAXV) ? MAXV : v, (v > MAXV), 1'b0);
        end
        send(fill(4'h1), 1'b0, 1'b0, 64, 1'b1, 1'b0);
        send(fill(4'h1), 1'b1, 1'b1, 64, 1'b0, 1'b0);
        drain();

        // reset with vectors in flight
        for (int i = 0; i < 4; i++) send(fill(4'hF), 1'b0, 1'b0, 960, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_sum", 32'(sum), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        check("postrst_in_ready", 32'(in_ready), 1);
        send(single(5, 4'h9), 1'b0, 1'b0, 9, 1'b0, 1'b1);
        idle(12);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
